// File: rtl/companion_history_engine.sv
// companion_history_engine
//   Trapezoidal companion-model history update for N_ELEM reactive elements,
//   one shared signed multiplier time-multiplexed across elements.
//   Per element k: prod = G_k * v_k; s = prod >>> FRAC_W;
//   inductor:  i_k <= i_k + s    capacitor: i_k <= -i_k + s
//
// Optional feature: define HIST_SAT_EN to saturate s and the sum to DATA_W
// and add a sticky sat_flag output; otherwise results wrap.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   cfg_we/idx/type/coef  per-element coefficient and type write (IDLE only)
//   hist_clr         zero all history currents (IDLE only, beats step_start)
//   step_start       start one step (IDLE only)
//   v_diff_flat      per-element branch voltage, element k at [k*DATA_W +: DATA_W]
//   busy             high from accepted start until step_done
//   step_done        one-cycle pulse after the last element is updated
//   hist_flat        history currents, same packing as v_diff_flat
//   step_cnt         completed-step counter (wraps)
//   sat_flag         sticky saturation flag (HIST_SAT_EN only)
module companion_history_engine #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int N_ELEM = 4,
    parameter int IDX_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_type,
    input  logic signed [DATA_W-1:0]   cfg_coef,
    input  logic                       hist_clr,
    input  logic                       step_start,
    input  logic [N_ELEM*DATA_W-1:0]   v_diff_flat,
    output logic                       busy,
    output logic                       step_done,
    output logic [N_ELEM*DATA_W-1:0]   hist_flat,
    output logic [15:0]                step_cnt
`ifdef HIST_SAT_EN
    ,
    output logic                       sat_flag
`endif
);

    localparam int PW = 2 * DATA_W;
    localparam int EW = DATA_W + 2;

    typedef enum logic [1:0] {StIdle, StMul, StAcc, StDone} state_e;

    state_e                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] coef  [N_ELEM];
    logic signed [DATA_W-1:0] vdiff [N_ELEM];
    logic signed [DATA_W-1:0] hist  [N_ELEM];
    logic [N_ELEM-1:0]        ctype;
    logic signed [PW-1:0]     prod;

    logic signed [DATA_W-1:0] s_red;
    logic signed [EW-1:0]     h_ext;
    logic signed [EW-1:0]     base;
    logic signed [EW-1:0]     sum_ext;
    logic signed [DATA_W-1:0] new_hist;

`ifdef HIST_SAT_EN
    localparam logic signed [DATA_W-1:0] WMax = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] WMin = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [PW-1:0] s_full;
    logic                 sat_hit;
    logic                 sat_seen;

    assign sat_flag = sat_seen;
`endif

    // Datapath for the ACC cycle of element idx.
    always_comb begin
        h_ext = EW'(hist[idx]);
        base  = ctype[idx] ? -h_ext : h_ext;
`ifdef HIST_SAT_EN
        s_full  = prod >>> FRAC_W;
        sat_hit = 1'b0;
        if (s_full > PW'(WMax)) begin
            s_red   = WMax;
            sat_hit = 1'b1;
        end else if (s_full < PW'(WMin)) begin
            s_red   = WMin;
            sat_hit = 1'b1;
        end else begin
            s_red = DATA_W'(s_full);
        end
        sum_ext = base + EW'(s_red);
        if (sum_ext > EW'(WMax)) begin
            new_hist = WMax;
            sat_hit  = 1'b1;
        end else if (sum_ext < EW'(WMin)) begin
            new_hist = WMin;
            sat_hit  = 1'b1;
        end else begin
            new_hist = DATA_W'(sum_ext);
        end
`else
        s_red    = DATA_W'(prod >>> FRAC_W);
        sum_ext  = base + EW'(s_red);
        new_hist = DATA_W'(sum_ext);
`endif
    end

    always_comb begin
        hist_flat = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            hist_flat[k*DATA_W +: DATA_W] = hist[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            idx       <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            step_cnt  <= '0;
            prod      <= '0;
            ctype     <= '0;
            for (int k = 0; k < N_ELEM; k++) begin
                coef[k]  <= '0;
                vdiff[k] <= '0;
                hist[k]  <= '0;
            end
`ifdef HIST_SAT_EN
            sat_seen <= 1'b0;
`endif
        end else begin
            step_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    // A same-cycle write commits before the first MUL reads it.
                    if (cfg_we && int'(cfg_idx) < N_ELEM) begin
                        coef[cfg_idx]  <= cfg_coef;
                        ctype[cfg_idx] <= cfg_type;
                    end
                    if (hist_clr) begin
                        for (int k = 0; k < N_ELEM; k++) hist[k] <= '0;
`ifdef HIST_SAT_EN
                        sat_seen <= 1'b0;
`endif
                    end else if (step_start) begin
                        for (int k = 0; k < N_ELEM; k++) begin
                            vdiff[k] <= v_diff_flat[k*DATA_W +: DATA_W];
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= StMul;
                    end
                end
                StMul: begin
                    prod  <= PW'(coef[idx]) * PW'(vdiff[idx]);
                    state <= StAcc;
                end
                StAcc: begin
                    hist[idx] <= new_hist;
`ifdef HIST_SAT_EN
                    if (sat_hit) sat_seen <= 1'b1;
`endif
                    if (idx == IDX_W'(N_ELEM - 1)) begin
                        state <= StDone;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= StMul;
                    end
                end
                StDone: begin
                    step_done <= 1'b1;
                    busy      <= 1'b0;
                    step_cnt  <= step_cnt + 16'd1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_companion_history_engine.sv
// Directed bench for companion_history_engine (default parameters).
// Expected values are hand-computed Q8.8 results.
module tb_companion_history_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic        cfg_type = 1'b0;
    logic [15:0] cfg_coef = '0;
    logic        hist_clr = 1'b0;
    logic        step_start = 1'b0;
    logic [63:0] v_diff_flat = '0;
    logic        busy;
    logic        step_done;
    logic [63:0] hist_flat;
    logic [15:0] step_cnt;
`ifdef HIST_SAT_EN
    logic        sat_flag;
`endif

    int checks = 0;
    int failures = 0;

    companion_history_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_type    (cfg_type),
        .cfg_coef    (cfg_coef),
        .hist_clr    (hist_clr),
        .step_start  (step_start),
        .v_diff_flat (v_diff_flat),
        .busy        (busy),
        .step_done   (step_done),
        .hist_flat   (hist_flat),
        .step_cnt    (step_cnt)
`ifdef HIST_SAT_EN
        ,
        .sat_flag    (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hist(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        check({tag, ".h0"}, 32'(hist_flat[15:0]), 32'(e0));
        check({tag, ".h1"}, 32'(hist_flat[31:16]), 32'(e1));
        check({tag, ".h2"}, 32'(hist_flat[47:32]), 32'(e2));
        check({tag, ".h3"}, 32'(hist_flat[63:48]), 32'(e3));
    endtask

    task automatic cfg_write(input logic [1:0] i, input logic t, input logic [15:0] g);
        cfg_we = 1'b1; cfg_idx = i; cfg_type = t; cfg_coef = g;
        tick();
        cfg_we = 1'b0;
    endtask

    // Starts a step and returns edges from the start edge to step_done (-1 on timeout).
    // With disturb set, start/cfg/clr are pulsed for one cycle while busy.
    task automatic run_step(input bit disturb, output int lat);
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (disturb && n == 3) begin
                step_start = 1'b1; hist_clr = 1'b1;
                cfg_we = 1'b1; cfg_idx = 2'd0; cfg_type = 1'b1; cfg_coef = 16'h0000;
            end
            tick();
            step_start = 1'b0; hist_clr = 1'b0; cfg_we = 1'b0;
            if (disturb && n == 4) check("busy_mid", 32'(busy), 32'd1);
            if (step_done) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;
    int pulses;

    initial begin
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(step_done), 32'd0);
        check("rst.cnt", 32'(step_cnt), 32'd0);
        check_hist("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        rst_n = 1'b1;
        tick();

        // e0 L 0x0080, e1 C 0x0100, e2 L 0x0001, e3 C 0xFF00
        cfg_write(2'd0, 1'b0, 16'h0080);
        cfg_write(2'd1, 1'b1, 16'h0100);
        cfg_write(2'd2, 1'b0, 16'h0001);
        cfg_write(2'd3, 1'b1, 16'hFF00);
        v_diff_flat = {16'h0200, 16'hFFFF, 16'h0100, 16'h0200};

        run_step(1'b0, lat);
        check("s1.lat", 32'(lat), 32'd9);
        check("s1.busy", 32'(busy), 32'd0);
        check("s1.cnt", 32'(step_cnt), 32'd1);
        check_hist("s1", 16'h0100, 16'h0100, 16'hFFFF, 16'hFE00);
        tick();
        check("s1.pulse", 32'(step_done), 32'd0);

        run_step(1'b0, lat);
        check("s2.lat", 32'(lat), 32'd9);
        check("s2.cnt", 32'(step_cnt), 32'd2);
        check_hist("s2", 16'h0200, 16'h0000, 16'hFFFE, 16'h0000);

        // Snapshot: vdiff changes after start must not matter.
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        v_diff_flat = '0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (step_done) begin lat = n; break; end
        end
        v_diff_flat = {16'h0200, 16'hFFFF, 16'h0100, 16'h0200};
        check("s3.lat", 32'(lat), 32'd9);
        check("s3.cnt", 32'(step_cnt), 32'd3);
        check_hist("s3", 16'h0300, 16'h0100, 16'hFFFD, 16'hFE00);

        // Start/cfg/clr while busy are ignored.
        run_step(1'b1, lat);
        check("s4.lat", 32'(lat), 32'd9);
        check_hist("s4", 16'h0400, 16'h0000, 16'hFFFC, 16'h0000);
        repeat (12) tick();
        check("s4.noqueue", 32'(step_cnt), 32'd4);
        check("s4.idle", 32'(busy), 32'd0);

        // Clear beats start in IDLE.
        hist_clr = 1'b1; step_start = 1'b1;
        tick();
        hist_clr = 1'b0; step_start = 1'b0;
        check("clr.busy", 32'(busy), 32'd0);
        check_hist("clr", 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (12) tick();
        check("clr.cnt", 32'(step_cnt), 32'd4);

        // Same-cycle write and start: step uses the new coefficient.
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_type = 1'b0; cfg_coef = 16'h0100;
        run_step(1'b0, lat);
        check("wst.lat", 32'(lat), 32'd9);
        check_hist("wst", 16'h0200, 16'h0100, 16'hFFFF, 16'hFE00);
        check("wst.cnt", 32'(step_cnt), 32'd5);

        // Reset asserted mid-step.
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.cnt", 32'(step_cnt), 32'd0);
        check_hist("mrst", 16'h0, 16'h0, 16'h0, 16'h0);
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (step_done) pulses++;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (step_done) pulses++;
        end
        check("mrst.nodone", 32'(pulses), 32'd0);
        cfg_write(2'd0, 1'b0, 16'h0080);
        run_step(1'b0, lat);
        check("post.lat", 32'(lat), 32'd9);
        check("post.cnt", 32'(step_cnt), 32'd1);
        check_hist("post", 16'h0100, 16'h0, 16'h0, 16'h0);

        // Overflow on element 0.
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        cfg_write(2'd0, 1'b0, 16'h7FFF);
        v_diff_flat = {16'h0200, 16'hFFFF, 16'h0100, 16'h7FFF};
`ifdef HIST_SAT_EN
        check("ovf.flag0", 32'(sat_flag), 32'd0);
`endif
        run_step(1'b0, lat);
        run_step(1'b0, lat);
        check("ovf.lat", 32'(lat), 32'd9);
`ifdef HIST_SAT_EN
        check("ovf.h0", 32'(hist_flat[15:0]), 32'h7FFF);
        check("ovf.flag", 32'(sat_flag), 32'd1);
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        check("ovf.flagclr", 32'(sat_flag), 32'd0);
`else
        // Exact sum 2*0x3FFF00 = 0x7FFE00; low 16 bits.
        check("ovf.h0", 32'(hist_flat[15:0]), 32'hFE00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
